fetch_unit: RTL and testbench

//   Fetch-side transmitter of the fetch->decode handshake: drives instruction/pc/valid and honours ready,

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_skid_buffer.sv | 70 +++++++
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V pipeline types and constants
package riscv_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  // addi x0,x0,0 - driven on the instruction bus whenever nothing is valid
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [DATA_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetched instruction together with the address it came from
  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - 2-entry FIFO of fetched {pc,instr} entries
module fetch_skid_buffer
  import riscv_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t slot0_q, slot0_d;
  fetch_entry_t slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_eff;
  logic         push_eff;

  // Slot 0 is always the head; a pop shifts slot 1 forward
  always_comb begin
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    count_d  = count_q;
    pop_eff  = pop_i && (count_q != 2'd0);
    push_eff = push_i && ((count_q != 2'd2) || pop_eff);
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_eff, pop_eff})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = push_data_i;
          else                 slot1_d = push_data_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            slot0_d = push_data_i;
          end else begin
            slot0_d = slot1_q;
            slot1_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage and occupancy registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = slot0_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, IMEM request issue and fetch->decode handshake
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_en,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  valid,
  input  logic                  ready
);

  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  pending_q, pending_d;
  logic [DATA_WIDTH-1:0] pending_pc_q, pending_pc_d;

  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_data;
  logic         push;
  logic         pop;
  logic         issue;
  logic [2:0]   occupancy;

  // Outputs come straight from the queue head register
  always_comb begin
    valid       = (count != 2'd0);
    pc          = valid ? head.pc : '0;
    instruction = valid ? head.instr : NOP_INSTR;
  end

  // Issue only when the slot for the returning data is guaranteed free
  always_comb begin
    pop       = valid && ready;
    occupancy = {1'b0, count} + {2'b00, pending_q} - {2'b00, pop};
    issue     = !rst && !redirect_valid && (occupancy < 3'd2);
    imem_en   = issue;
    imem_addr = fetch_pc_q;
    push      = pending_q && !redirect_valid && !rst;
    push_data = '{pc: pending_pc_q, instr: imem_rdata};
  end

  // Next fetch address and in-flight bookkeeping; a redirect drops the in-flight read
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pending_d    = issue;
    pending_pc_d = pending_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & {{(DATA_WIDTH-2){1'b1}}, 2'b00};
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (issue) begin
      pending_pc_d = fetch_pc_q;
    end
  end

  // Fetch PC and pending-read registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head)
  );

  // The issue rule must keep a full queue from ever receiving data
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (rst) !(push && (count == 2'd2))
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready_a;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        imem_en_a, valid_a;
  logic [31:0] imem_addr_a, imem_rdata_a, instruction_a, pc_a;

  logic        imem_en_b, valid_b;
  logic [31:0] imem_addr_b, imem_rdata_b, instruction_b, pc_b;
  logic        ready_b = 1'b1;
  logic        redirect_valid_b = 1'b0;
  logic [31:0] redirect_pc_b = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;
  int pops_pc4 = 0;
  int pops_stale = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .imem_en(imem_en_a), .imem_addr(imem_addr_a),
    .imem_rdata(imem_rdata_a), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instruction(instruction_a), .pc(pc_a),
    .valid(valid_a), .ready(ready_a)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst(rst), .imem_en(imem_en_b), .imem_addr(imem_addr_b),
    .imem_rdata(imem_rdata_b), .redirect_valid(redirect_valid_b),
    .redirect_pc(redirect_pc_b), .instruction(instruction_b), .pc(pc_b),
    .valid(valid_b), .ready(ready_b)
  );

  // IMEM: word i holds 0x1000_0000 + i, one cycle read latency
  always @(posedge clk) begin
    if (imem_en_a) imem_rdata_a <= 32'h1000_0000 + (imem_addr_a >> 2);
    if (imem_en_b) imem_rdata_b <= 32'h1000_0000 + (imem_addr_b >> 2);
  end

  // Transfer monitor on the decode side
  always @(posedge clk) begin
    if (valid_a && ready_a) begin
      if (pc_a == 32'h4) pops_pc4 <= pops_pc4 + 1;
      if (pc_a == 32'hC || pc_a == 32'h10) pops_stale <= pops_stale + 1;
    end
  end

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    ready_a = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid_a) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'b0, ok}, 32'h1);
  endtask

  initial begin
    int snap;
    rst = 1'b1;
    ready_a = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'b0, valid_a}, 32'h0);
    check("rst_pc", pc_a, 32'h0);
    check("rst_instr", instruction_a, NOP_INSTR);
    check("rst_imem_en", {31'b0, imem_en_a}, 32'h0);

    // 1: streaming with ready held high; dut_b wraps past 0xFFFF_FFFC
    ready_a = 1'b1;
    rst = 1'b0;
    #1;
    check("c0_imem_en", {31'b0, imem_en_a}, 32'h1);
    check("c0_imem_addr", imem_addr_a, 32'h0);
    @(negedge clk);
    check("c1_valid", {31'b0, valid_a}, 32'h0);
    @(negedge clk);
    check("c2_valid", {31'b0, valid_a}, 32'h1);
    check("c2_pc", pc_a, 32'h0);
    check("c2_instr", instruction_a, 32'h1000_0000);
    check("b_pc0", pc_b, 32'hFFFF_FFF8);
    check("b_instr0", instruction_b, imem_word(32'hFFFF_FFF8));
    @(negedge clk);
    check("c3_pc", pc_a, 32'h4);
    check("c3_instr", instruction_a, 32'h1000_0001);
    check("b_pc1", pc_b, 32'hFFFF_FFFC);
    @(negedge clk);
    check("c4_pc", pc_a, 32'h8);
    check("b_pc2", pc_b, 32'h0);
    check("b_instr2", instruction_b, 32'h1000_0000);

    // 2: decode stall with pc 0x8 at head
    ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, valid_a}, 32'h1);
      check("stall_pc", pc_a, 32'h8);
      check("stall_instr", instruction_a, 32'h1000_0002);
      check("stall_imem_en", {31'b0, imem_en_a}, 32'h0);
    end
    ready_a = 1'b1;
    @(negedge clk);
    check("rel_pc_c", pc_a, 32'hC);
    check("rel_instr_c", instruction_a, 32'h1000_0003);
    @(negedge clk);
    check("rel_valid", {31'b0, valid_a}, 32'h1);
    check("rel_pc_10", pc_a, 32'h10);

    // 3: redirect with the queue full of 0x8, 0xC
    do_reset();
    repeat (4) @(negedge clk);
    check("t3_head", pc_a, 32'h8);
    ready_a = 1'b0;
    @(negedge clk);
    check("t3_full_en", {31'b0, imem_en_a}, 32'h0);
    snap = pops_stale;
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    #1;
    check("t3_redir_en", {31'b0, imem_en_a}, 32'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t3_valid_drop", {31'b0, valid_a}, 32'h0);
    ready_a = 1'b1;
    #1;
    check("t3_issue_en", {31'b0, imem_en_a}, 32'h1);
    check("t3_issue_addr", imem_addr_a, 32'h100);
    wait_valid("t3_wait");
    check("t3_pc", pc_a, 32'h100);
    check("t3_instr", instruction_a, 32'h1000_0040);
    check("t3_no_stale", snap, pops_stale);
    @(negedge clk);
    check("t3_pc_next", pc_a, 32'h104);

    // 4: redirect coinciding with the pop of pc 0x4
    do_reset();
    repeat (3) @(negedge clk);
    check("t4_head", pc_a, 32'h4);
    snap = pops_pc4;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("t4_valid_drop", {31'b0, valid_a}, 32'h0);
    check("t4_pc4_once", pops_pc4, snap + 1);
    wait_valid("t4_wait");
    check("t4_pc", pc_a, 32'h200);
    check("t4_instr", instruction_a, 32'h1000_0080);
    check("t4_pc4_final", pops_pc4, snap + 1);

    // 6: one-cycle reset while valid and a read is pending
    do_reset();
    repeat (4) @(negedge clk);
    check("t6_pre_valid", {31'b0, valid_a}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_valid", {31'b0, valid_a}, 32'h0);
    check("t6_instr", instruction_a, NOP_INSTR);
    check("t6_pc", pc_a, 32'h0);
    rst = 1'b0;
    #1;
    check("t6_en", {31'b0, imem_en_a}, 32'h1);
    check("t6_addr", imem_addr_a, 32'h0);
    @(negedge clk);
    check("t6_no_stale", {31'b0, valid_a}, 32'h0);
    @(negedge clk);
    check("t6_restart_pc", pc_a, 32'h0);
    check("t6_restart_instr", instruction_a, 32'h1000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
